// File: rtl/req_queue_bank_if.sv
// Handshake/bus bundle for req_queue_bank.
// Carries the per-port write side (valid/data/ready), the arbiter link
// (req/gnt/pop), the single output register (valid/data/port/ready), and
// the sticky illegal-grant flag. The slave modport is the queue bank;
// the master modport is whoever drives the requesters, arbiter and sink.
interface req_queue_bank_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DW        = 8
);
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]    in_valid_i;
    logic [NUM_PORTS*DW-1:0] in_data_i;
    logic [NUM_PORTS-1:0]    in_ready_o;
    logic [NUM_PORTS-1:0]    req_o;
    logic [NUM_PORTS-1:0]    gnt_i;
    logic [NUM_PORTS-1:0]    pop_o;
    logic                    out_valid_o;
    logic [DW-1:0]           out_data_o;
    logic [PW-1:0]           out_port_o;
    logic                    out_ready_i;
    logic                    gnt_err_o;

    modport slave (
        input  in_valid_i, in_data_i, gnt_i, out_ready_i,
        output in_ready_o, req_o, pop_o, out_valid_o, out_data_o, out_port_o, gnt_err_o
    );

    modport master (
        output in_valid_i, in_data_i, gnt_i, out_ready_i,
        input  in_ready_o, req_o, pop_o, out_valid_o, out_data_o, out_port_o, gnt_err_o
    );
endinterface

// File: rtl/req_queue_bank.sv
// Bank of per-port request FIFOs feeding one output register under an
// external one-hot grant.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   bus.slave   in_valid_i/in_data_i/in_ready_o : per-port push side
//               req_o (non-empty) / gnt_i / pop_o : arbiter link
//               out_valid_o/out_data_o/out_port_o/out_ready_i : output register
//               gnt_err_o : sticky multi-hot grant flag
module req_queue_bank #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    req_queue_bank_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]    wr_ptr_q [NUM_PORTS];
    logic [AW:0]    wr_ptr_d [NUM_PORTS];
    logic [AW:0]    rd_ptr_q [NUM_PORTS];
    logic [AW:0]    rd_ptr_d [NUM_PORTS];
    logic [DW-1:0]  mem_q    [NUM_PORTS][DEPTH];

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q,  out_data_d;
    logic [PW-1:0]  out_port_q,  out_port_d;
    logic           gnt_err_q,   gnt_err_d;

    logic [NUM_PORTS-1:0] full_c;
    logic [NUM_PORTS-1:0] empty_c;
    logic [NUM_PORTS-1:0] push_c;
    logic [NUM_PORTS-1:0] pop_c;
    logic                 gnt_multi_c;
    logic                 gnt_one_hot_c;
    logic                 out_free_c;
    logic [PW-1:0]        gnt_idx_c;

    // FIFO status and push qualification, all from registered pointers.
    always_comb begin
        full_c  = '0;
        empty_c = '0;
        push_c  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            full_c[p]  = (wr_ptr_q[p] == {~rd_ptr_q[p][AW], rd_ptr_q[p][AW-1:0]});
            empty_c[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            push_c[p]  = bus.in_valid_i[p] && !full_c[p];
        end
    end

    // Grant legality and pop decision; a pop needs room in the output register.
    always_comb begin
        gnt_multi_c   = (bus.gnt_i & (bus.gnt_i - NUM_PORTS'(1))) != '0;
        gnt_one_hot_c = (bus.gnt_i != '0) && !gnt_multi_c;
        out_free_c    = !out_valid_q || bus.out_ready_i;
        pop_c         = (gnt_one_hot_c && out_free_c) ? (bus.gnt_i & ~empty_c) : '0;
        gnt_idx_c     = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (bus.gnt_i[p]) begin
                gnt_idx_c = PW'(p);
            end
        end
    end

    // Pointer advance.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + (AW+1)'(push_c[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + (AW+1)'(pop_c[p]);
        end
    end

    // Output register next state; data/port keep last values when drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        gnt_err_d   = gnt_err_q | gnt_multi_c;
        if (pop_c != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[gnt_idx_c][rd_ptr_q[gnt_idx_c][AW-1:0]];
            out_port_d  = gnt_idx_c;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            gnt_err_q   <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            gnt_err_q   <= gnt_err_d;
        end
    end

    // FIFO storage; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (push_c[p]) begin
                mem_q[p][wr_ptr_q[p][AW-1:0]] <= bus.in_data_i[p*DW +: DW];
            end
        end
    end

    assign bus.in_ready_o  = ~full_c;
    assign bus.req_o       = ~empty_c;
    assign bus.pop_o       = pop_c;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_port_o  = out_port_q;
    assign bus.gnt_err_o   = gnt_err_q;
endmodule

// File: tb/tb_req_queue_bank.sv
// Scoreboard bench for req_queue_bank: stimulus pushes expected output
// entries; an independent monitor pops and compares on every accepted output.
module tb_req_queue_bank;
    localparam int unsigned NP = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    req_queue_bank_if #(.NUM_PORTS(NP), .DW(DW)) bus ();

    req_queue_bank #(.NUM_PORTS(NP), .DW(DW), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] port;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 units after the falling edge, well clear of the rising edge.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic expect_out(input logic [7:0] d, input int p);
        exp_t e;
        e.data = d;
        e.port = 2'(p);
        sb.push_back(e);
    endtask

    task automatic drive_push(input int p, input logic [7:0] d);
        bus.in_valid_i = NP'(1) << p;
        bus.in_data_i[p*DW +: DW] = d;
        step();
        bus.in_valid_i = '0;
    endtask

    task automatic grant(input logic [3:0] g, input logic [3:0] exp_pop, input logic [7:0] d, input int p);
        bus.gnt_i = g;
        #1;
        chk("pop_o", 32'(bus.pop_o), 32'(exp_pop));
        if (exp_pop != '0) expect_out(d, p);
        step();
        bus.gnt_i = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},       32'(bus.req_o),       32'h0);
        chk({tag, "_pop"},       32'(bus.pop_o),       32'h0);
        chk({tag, "_in_ready"},  32'(bus.in_ready_o),  32'hF);
        chk({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'h0);
        chk({tag, "_out_data"},  32'(bus.out_data_o),  32'h0);
        chk({tag, "_out_port"},  32'(bus.out_port_o),  32'h0);
        chk({tag, "_gnt_err"},   32'(bus.gnt_err_o),   32'h0);
    endtask

    // Monitor: one sample per cycle, just before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data 0x%0h port %0d, expected none at %0t",
                             bus.out_data_o, bus.out_port_o, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(bus.out_data_o), 32'(e.data));
                    chk("out_port", 32'(bus.out_port_o), 32'(e.port));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         last;
        int         cycles;
        logic [3:0] g;
        logic       found;

        bus.in_valid_i  = '0;
        bus.in_data_i   = '0;
        bus.gnt_i       = '0;
        bus.out_ready_i = 1'b1;
        reset           = 1'b1;

        // Reset state.
        #1;
        chk_reset_outputs("rst");
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;

        // Single push on port 2, granted next cycle.
        drive_push(2, 8'h11);
        chk("t1_req", 32'(bus.req_o), 32'h4);
        grant(4'b0100, 4'b0100, 8'h11, 2);
        chk("t1_req_after", 32'(bus.req_o), 32'h0);
        chk("t1_valid", 32'(bus.out_valid_o), 32'h1);
        step();
        chk("t1_drained", 32'(bus.out_valid_o), 32'h0);
        chk("t1_data_kept", 32'(bus.out_data_o), 32'h11);

        // Fill port 0, overflow write dropped, drain in order.
        for (int i = 0; i < 4; i++) drive_push(0, 8'(8'hA0 + i));
        chk("t2_full_ready", 32'(bus.in_ready_o), 32'hE);
        drive_push(0, 8'hEE);
        chk("t2_still_full", 32'(bus.in_ready_o), 32'hE);
        for (int i = 0; i < 4; i++) grant(4'b0001, 4'b0001, 8'(8'hA0 + i), 0);
        chk("t2_empty_req", 32'(bus.req_o), 32'h0);
        chk("t2_ready_back", 32'(bus.in_ready_o), 32'hF);

        // Stalled output holds 0xA5; grant to non-empty port 1 is ignored.
        drive_push(1, 8'h55);
        drive_push(1, 8'h66);
        drive_push(3, 8'hA5);
        bus.out_ready_i = 1'b0;
        grant(4'b1000, 4'b1000, 8'hA5, 3);
        for (int i = 0; i < 2; i++) begin
            grant(4'b0010, 4'b0000, 8'h00, 0);
            chk("t3_valid_held", 32'(bus.out_valid_o), 32'h1);
            chk("t3_data_held", 32'(bus.out_data_o), 32'hA5);
            chk("t3_port_held", 32'(bus.out_port_o), 32'h3);
            chk("t3_req", 32'(bus.req_o), 32'h2);
        end
        bus.out_ready_i = 1'b1;
        step();
        grant(4'b0010, 4'b0010, 8'h55, 1);
        grant(4'b0010, 4'b0010, 8'h66, 1);
        chk("t3_port1_empty", 32'(bus.req_o), 32'h0);

        // Push refused on full even while popping; push+pop on 3 and 1 entries.
        for (int i = 0; i < 4; i++) drive_push(0, 8'(8'hB0 + i));
        bus.in_valid_i = 4'b0001;
        bus.in_data_i[7:0] = 8'hEF;
        bus.gnt_i = 4'b0001;
        #1;
        chk("t4_full_refused", 32'(bus.in_ready_o[0]), 32'h0);
        chk("t4_pop_full", 32'(bus.pop_o), 32'h1);
        expect_out(8'hB0, 0);
        step();
        bus.in_data_i[7:0] = 8'hC4;
        #1;
        chk("t4_ready_3", 32'(bus.in_ready_o[0]), 32'h1);
        chk("t4_pop_3", 32'(bus.pop_o), 32'h1);
        expect_out(8'hB1, 0);
        step();
        bus.in_valid_i = '0;
        bus.gnt_i = '0;
        grant(4'b0001, 4'b0001, 8'hB2, 0);
        grant(4'b0001, 4'b0001, 8'hB3, 0);
        grant(4'b0001, 4'b0001, 8'hC4, 0);
        chk("t4_empty", 32'(bus.req_o), 32'h0);
        drive_push(0, 8'hD1);
        bus.in_valid_i = 4'b0001;
        bus.in_data_i[7:0] = 8'hD2;
        grant(4'b0001, 4'b0001, 8'hD1, 0);
        bus.in_valid_i = '0;
        chk("t4_one_entry_kept", 32'(bus.req_o), 32'h1);
        grant(4'b0001, 4'b0001, 8'hD2, 0);
        chk("t4_empty2", 32'(bus.req_o), 32'h0);

        // Multi-hot grant: no pop, sticky error.
        drive_push(0, 8'hE0);
        drive_push(1, 8'hE1);
        chk("t5_err_before", 32'(bus.gnt_err_o), 32'h0);
        grant(4'b0011, 4'b0000, 8'h00, 0);
        chk("t5_err_set", 32'(bus.gnt_err_o), 32'h1);
        chk("t5_no_pop_req", 32'(bus.req_o), 32'h3);
        grant(4'b0001, 4'b0001, 8'hE0, 0);
        grant(4'b0010, 4'b0010, 8'hE1, 1);
        chk("t5_err_sticky", 32'(bus.gnt_err_o), 32'h1);

        // Round-robin loop over four preloaded ports.
        bus.in_valid_i = 4'b1111;
        bus.in_data_i = {8'h30, 8'h20, 8'h10, 8'h00};
        step();
        bus.in_data_i = {8'h31, 8'h21, 8'h11, 8'h01};
        step();
        bus.in_valid_i = '0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) expect_out(8'(p * 16 + k), p);
        last = 3;
        cycles = 0;
        while (bus.req_o != '0 && cycles < 20) begin
            g = '0;
            found = 1'b0;
            for (int off = 1; off <= 4; off++) begin
                if (!found && bus.req_o[(last + off) % 4]) begin
                    g = 4'(1) << ((last + off) % 4);
                    last = (last + off) % 4;
                    found = 1'b1;
                end
            end
            bus.gnt_i = g;
            step();
            cycles++;
        end
        bus.gnt_i = '0;
        chk("t6_rr_cycles", 32'(cycles), 32'd8);
        chk("t6_req_empty", 32'(bus.req_o), 32'h0);
        step();
        chk("t6_sb_drained", 32'(sb.size()), 32'h0);

        // Reset mid-operation discards queued and held entries.
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) drive_push(2, 8'(8'hF0 + i));
        bus.gnt_i = 4'b0100;
        step();
        bus.gnt_i = '0;
        chk("t7_held", 32'(bus.out_valid_o), 32'h1);
        chk("t7_queued", 32'(bus.req_o), 32'h4);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("t7_rst");
        step();
        reset = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            grant(4'b0100, 4'b0000, 8'h00, 0);
            chk("t7_no_output", 32'(bus.out_valid_o), 32'h0);
        end
        drive_push(2, 8'hF9);
        grant(4'b0100, 4'b0100, 8'hF9, 2);
        step();
        step();
        chk("t7_sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/req_queue_bank.md
REQ_QUEUE_BANK -- requirements
Module: req_queue_bank

Interface
REQ-001 Parameters SHALL be: NUM_PORTS, default 4, number of requester ports; DW, default 8, payload width in bits; DEPTH, default 4, entries per port FIFO (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid_i  input  NUM_PORTS  per-port write strobe.
REQ-005 in_data_i  input  NUM_PORTS*DW  per-port payload; port p occupies bits [p*DW +: DW].
REQ-006 in_ready_o  output  NUM_PORTS  per-port space available.
REQ-007 req_o  output  NUM_PORTS  per-port non-empty flag; drives the round-robin arbiter req_i.
REQ-008 gnt_i  input  NUM_PORTS  one-hot grant from the round-robin arbiter gnt_o.
REQ-009 pop_o  output  NUM_PORTS  one-hot; bit p high in the cycle port p's head entry is consumed.
REQ-010 out_valid_o  output  1  output register holds a valid entry.
REQ-011 out_data_o  output  DW  payload of the held entry.
REQ-012 out_port_o  output  clog2(NUM_PORTS)  source port index of the held entry.
REQ-013 out_ready_i  input  1  downstream accepts the held entry this cycle.
REQ-014 gnt_err_o  output  1  sticky flag: illegal grant seen.

Function
REQ-015 Each port SHALL own an independent DEPTH-entry FIFO; read/write pointers carry one extra wrap bit; full = pointers equal except wrap bit; empty = pointers equal.
REQ-016 in_ready_o[p] SHALL be combinational !full[p]; a push SHALL occur when in_valid_i[p] && in_ready_o[p].
REQ-017 in_valid_i[p] while full SHALL be dropped without corrupting state; no write-through bypass on full.
REQ-018 req_o[p] SHALL be !empty[p], derived only from registered pointers; data pushed at edge N SHALL raise req_o at N and be poppable no earlier than edge N+1.
REQ-019 A grant is legal when gnt_i is exactly one-hot; grant is effective when legal, req_o of the granted port is 1, and (out_valid_o==0 || out_ready_i==1).
REQ-020 On an effective grant to port p: pop_o[p]=1 combinationally; at the next edge, head entry moves to the output register, out_port_o=p, out_valid_o=1, read pointer p advances with wrap.
REQ-021 gnt_i==0, a grant to an empty port, or a grant while the output is stalled SHALL cause no pop and pop_o=0.
REQ-022 Multi-hot gnt_i SHALL cause no pop and SHALL set gnt_err_o at the next edge; gnt_err_o SHALL hold 1 until reset.
REQ-023 out_valid_o && !out_ready_i SHALL hold out_valid_o, out_data_o, out_port_o stable.
REQ-024 out_valid_o && out_ready_i with no effective grant SHALL clear out_valid_o at the next edge; out_data_o/out_port_o keep last values.
REQ-025 Simultaneous push and pop on the same port SHALL both take effect (count unchanged), including when the FIFO holds exactly one entry.
REQ-026 Push into a full FIFO in the same cycle as its pop SHALL still be refused (in_ready_o from pre-pop state).
REQ-027 Throughput SHALL be one entry per cycle when out_ready_i is held 1 and grants are effective.

Reset
REQ-028 reset asserted SHALL immediately clear all pointers, out_valid_o=0, out_data_o=0, out_port_o=0, gnt_err_o=0; hence req_o=0, pop_o=0, in_ready_o=all ones.
REQ-029 reset asserted mid-operation SHALL discard all queued and held entries; no entry SHALL appear at the output after reset deassertion until newly pushed.

Verification
REQ-030 Reset, push 0x11 on port 2 at edge 1, gnt_i=4'b0100 from cycle 2, out_ready_i=1 -> req_o=4'b0100 after edge 1, pop_o[2]=1 in cycle 2, out_valid_o=1/out_data_o=0x11/out_port_o=2 after edge 2, req_o=0.
REQ-031 Push 4 entries on port 0 with no grant -> in_ready_o[0]=0 after 4th push; 5th write dropped; 4 later grants yield the first 4 values in order, then req_o[0]=0.
REQ-032 Output stalled (out_ready_i=0) with valid held 0xA5 and gnt_i=4'b0010 on non-empty port 1 -> pop_o=0, outputs stay 0xA5, port 1 count unchanged.
REQ-033 gnt_i=4'b0011 with ports 0 and 1 non-empty -> no pop, gnt_err_o=1 next edge and held through later legal grants until reset.
REQ-034 Round-robin loop with the arbiter, all four ports preloaded with 2 entries, out_ready_i=1 -> 8 outputs, one per cycle, port order 0,1,2,3,0,1,2,3, then req_o=0.
REQ-035 Assert reset with 3 entries queued and out_valid_o=1 -> all outputs at reset values immediately; after release, no output until a new push.
